pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Consumer side of the load-use hazard interface: applies the registered halt[4:0] vector from
//  the hazard unit, plus branch redirects and data-memory wait, to the 5-stage pipeline registers.
//  Sits between the hazard unit and the IF/ID/EX/MEM/WB register banks. Drives per-stage enable
//  and bubble (NOP) inserts, and holds PC. A skid register replays the fetch word that the
//  synchronous IMEM returns while ID is frozen.
// PARAMETERS
//  XLEN       32      instruction/PC width
//  MAX_STALL  16      consecutive hazard-stall cycles before stall_err is set
//  CNT_W      16      width of stall_cycles performance counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  halt_req      in   5      hazard halt vector; [4]=IF [3]=ID [2]=EX [1]=MEM [0]=WB, 1=freeze
//  taken_branch  in   1      branch resolved taken in EX this cycle
//  dmem_busy     in   1      data memory not ready; freeze entire pipe
//  if_instr      in   XLEN   IMEM read data (1-cycle latency after PC)
//  stage_en      out  5      pipeline register load enable, same bit order as halt_req
//  stage_bubble  out  5      load NOP (0x00000013) into that stage register instead of upstream data
//  pc_hold       out  1      PC register must not advance
//  pc_redirect   out  1      PC loads branch target this cycle
//  id_instr      out  XLEN   instruction word presented to IF/ID register
//  stall_cycles  out  CNT_W  saturating count of cycles with any stage frozen
//  stall_err     out  1      sticky: halt_req nonzero for > MAX_STALL consecutive cycles
// BEHAVIOUR
//  Reset: state=RUN, skid_valid=0, stall_cycles=0, stall_err=0, hz_cnt=0; during reset
//   stage_en=0, stage_bubble=5'b11111, pc_hold=1, pc_redirect=0, id_instr=NOP.
//  States: RUN, MEMW, HAZ, FLUSH. Priority per cycle: dmem_busy > halt_req!=0 > taken_branch.
//  MEMW (dmem_busy=1): stage_en=0, stage_bubble=0, pc_hold=1; taken_branch ignored (EX frozen,
//   so it persists until release). Exit to RUN on the first cycle dmem_busy=0.
//  HAZ (halt_req!=0, no dmem_busy): stage_en=~halt_req; for i in 0..3,
//   stage_bubble[i]=halt_req[i+1]&~halt_req[i] (5'b11100 -> en=00011, bubble=00010);
//   pc_hold=halt_req[4]. hz_cnt increments; at hz_cnt==MAX_STALL, stall_err<=1 (sticky until
//   reset). hz_cnt clears when halt_req==0.
//  FLUSH: on taken_branch in RUN, pc_redirect=1 and bubble[4:3]=11 this cycle (squash IF, ID).
//   Next cycle state=FLUSH: bubble[3]=1 again (discard the stale IMEM word in flight) and
//   pc_redirect=0. Then RUN. taken_branch in FLUSH is illegal (flushed); ignore it.
//  Skid: if IF/ID is frozen (stage_en[3]=0) while the previous cycle issued a fresh PC, capture
//   if_instr, skid_valid<=1. On the first cycle with stage_en[3]=1, id_instr=skid and
//   skid_valid<=0; otherwise id_instr=if_instr. Bubbles on ID or FLUSH entry clear skid_valid.
//  stall_cycles: +1 on each cycle with any stage_en bit 0 (excluding reset); saturates at all-1s.
//  Simultaneous dmem_busy and halt_req: MEMW wins; halt_req remains registered upstream and is
//   applied after release. Reset mid-stall: all state returns to reset values immediately (async).
//  Latency: all stage_en/bubble/pc outputs are combinational from state and inputs (0 cycles);
//   state, skid, and counters are registered.
// STRUCTURE
//  Shared package pipe_pkg: stage index enum (IF=4..WB=0), NOP_INSTR, ctrl_state_e
//   {RUN,MEMW,HAZ,FLUSH}. LOAD opcode already lives in define.sv.
//  One sub-module: skid_reg (XLEN-wide 1-entry capture/replay register with valid).
// TESTING
//  1 halt_req=5'b11100 for 1 cycle -> stage_en=00011, stage_bubble=00010, pc_hold=1; next RUN.
//  2 taken_branch in RUN -> pc_redirect=1, bubble=11000; next cycle bubble=01000, then all-0.
//  3 dmem_busy 3 cycles with taken_branch held -> en=0 for 3 cycles, then redirect on release.
//  4 Freeze ID while if_instr=0x00A00093 -> released id_instr=0x00A00093, not the next word.
//  5 halt_req held 17 cycles (MAX_STALL=16) -> stall_err=1, stays 1 after halt_req=0.
//  6 rst low mid-HAZ -> outputs at reset values same cycle; counter=0, skid_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: stage indices, NOP encoding and controller states.
package pipe_pkg;

    // Bit positions in halt_req / stage_en / stage_bubble.
    typedef enum logic [2:0] {
        StWb  = 3'd0,
        StMem = 3'd1,
        StEx  = 3'd2,
        StId  = 3'd3,
        StIf  = 3'd4
    } stage_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StMemw  = 2'd1,
        StHaz   = 2'd2,
        StFlush = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/skid_reg.sv
// One-entry capture/replay register holding the fetch word returned while IF/ID is frozen.
module skid_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             clear_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // Clear wins over capture; data only changes on capture.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    // Entry storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Applies hazard halts, data-memory wait and branch flushes to the 5-stage pipeline registers.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MAX_STALL = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      halt_req,
    input  logic            taken_branch,
    input  logic            dmem_busy,
    input  logic [XLEN-1:0] if_instr,
    output logic [4:0]      stage_en,
    output logic [4:0]      stage_bubble,
    output logic            pc_hold,
    output logic            pc_redirect,
    output logic [XLEN-1:0] id_instr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic            stall_err
);

    localparam int unsigned HzW = $clog2(MAX_STALL + 1);

    ctrl_state_e      state_q, state_d;
    logic [HzW-1:0]   hz_cnt_q, hz_cnt_d;
    logic             stall_err_q, stall_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             fresh_pc_q, fresh_pc_d;
    logic             haz_active;
    logic             skid_valid, skid_capture, skid_clear;
    logic [XLEN-1:0]  skid_data;

    // Per-cycle decode: dmem_busy > halt_req > pending flush > new branch; reset forces safe values.
    always_comb begin
        state_d      = StRun;
        stage_en     = '1;
        stage_bubble = '0;
        pc_hold      = 1'b0;
        pc_redirect  = 1'b0;
        haz_active   = 1'b0;
        if (dmem_busy) begin
            // EX is frozen too, so a taken branch is simply seen again after release.
            state_d  = StMemw;
            stage_en = '0;
            pc_hold  = 1'b1;
        end else if (halt_req != 5'b0) begin
            state_d    = StHaz;
            haz_active = 1'b1;
            stage_en   = ~halt_req;
            // A running stage directly below a frozen one must take a bubble.
            for (int i = 0; i < 4; i++) begin
                stage_bubble[i] = halt_req[i+1] & ~halt_req[i];
            end
            pc_hold = halt_req[StIf];
        end else if (state_q == StFlush) begin
            // Discard the wrong-path IMEM word still in flight; branches here are ignored.
            stage_bubble[StId] = 1'b1;
        end else if (taken_branch) begin
            state_d            = StFlush;
            pc_redirect        = 1'b1;
            stage_bubble[StIf] = 1'b1;
            stage_bubble[StId] = 1'b1;
        end
        if (!rst) begin
            stage_en     = '0;
            stage_bubble = '1;
            pc_hold      = 1'b1;
            pc_redirect  = 1'b0;
        end
    end

    // Replay the skid word on the first cycle ID loads again.
    always_comb begin
        id_instr = if_instr;
        if (!rst) begin
            id_instr = XLEN'(NopInstr);
        end else if (stage_en[StId] && skid_valid) begin
            id_instr = skid_data;
        end
    end

    // Capture only a word fetched for a freshly issued (non-redirect) PC.
    always_comb begin
        skid_clear   = stage_bubble[StId] | stage_en[StId];
        skid_capture = ~stage_en[StId] & fresh_pc_q & ~skid_valid;
    end

    // Watchdog, performance counter and fresh-PC tracking next state.
    always_comb begin
        hz_cnt_d       = hz_cnt_q;
        stall_err_d    = stall_err_q;
        stall_cycles_d = stall_cycles_q;
        fresh_pc_d     = ~pc_hold & ~pc_redirect;
        if (haz_active) begin
            if (hz_cnt_q >= HzW'(MAX_STALL)) begin
                stall_err_d = 1'b1;
            end else begin
                hz_cnt_d = hz_cnt_q + 1'b1;
            end
        end else if (halt_req == 5'b0) begin
            hz_cnt_d = '0;
        end
        if (stage_en != 5'h1f && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // Controller state and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StRun;
            hz_cnt_q       <= '0;
            stall_err_q    <= 1'b0;
            stall_cycles_q <= '0;
            fresh_pc_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            hz_cnt_q       <= hz_cnt_d;
            stall_err_q    <= stall_err_d;
            stall_cycles_q <= stall_cycles_d;
            fresh_pc_q     <= fresh_pc_d;
        end
    end

    skid_reg #(
        .Width (XLEN)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .capture_i (skid_capture),
        .clear_i   (skid_clear),
        .data_i    (if_instr),
        .valid_o   (skid_valid),
        .data_o    (skid_data)
    );

    assign stall_cycles = stall_cycles_q;
    assign stall_err    = stall_err_q;

endmodule
